ctrl_pipe_unit: RTL
===================

CTRL_PIPE_UNIT -- requirements
Module: ctrl_pipe_unit

Interface
REQ-001 SHALL provide parameter M_EXT, default 1, enabling RV32M multiply/divide decode and sequencing.
REQ-002 SHALL provide parameter MUL_LAT, default 4, giving multiply busy cycles (range 1..63).
REQ-003 SHALL provide parameter DIV_LAT, default 32, giving divide/remainder busy cycles (range 1..63).
REQ-004 Ports: one clock; reset is asynchronous and active-high.
- CLK_i  in  1  clock, rising edge.
- RST_i  in  1  asynchronous active-high reset.
- INSTR_VLD_i  in  1  ID-stage instruction valid.
- OP_CD_i, FUNCT3_i, FUNCT7_i  in  7/3/7  instruction fields.
- RS1_i, RS2_i, RD_i  in  5 each  register indices.
- STALL_i  in  1  downstream hold.
- FLUSH_i  in  1  taken branch/jump kill.
- JUMP_o 2, BRANCH_o 3, RSLT_o 2, MEM_WRT_o 1, ALU_SRC_o 1, IMM_SRC_o 2, REG_WRT_o 1  out  registered EX-stage controls.
- ALU_CTRL_o  out  5  registered ALU operation.
- EX_VLD_o  out  1  EX-stage contents valid.
- EX_RD_o  out  5  EX-stage destination register.
- ID_STALL_o  out  1  hold fetch/decode, combinational.
- MD_BUSY_o  out  1  multi-cycle operation in progress.
- ILLEGAL_o  out  1  registered one-cycle flag for an unsupported opcode.

Function
REQ-005 Decode SHALL use these encodings:
- BRANCH: beq=1, bne=2, blt/bltu=3, bge/bgeu=4.
- JUMP: jal=1, jalr=2.
- RSLT: load=1, jal=2, lui/auipc=3, else 0.
- IMM_SRC: B=10, J=11, U=01, else 00.
- ALU_SRC: load, store, op-imm, jalr.
- MEM_WRT: store only.
- REG_WRT: load, op, op-imm, jal, jalr, lui, auipc.
REQ-006 ALU_CTRL SHALL be:
- {0,funct3,funct7[5]} for op and for op-imm with funct3=5.
- 0 for load/jalr.
- 5'b00001 for branch.
- {0,funct3,0} otherwise.
- {1,0,funct3} for M ops (opcode 0110011, funct7=0000001) when M_EXT=1.
REQ-007 All EX outputs SHALL register on the edge following accepted decode; latency is 1 cycle.
REQ-008 A load-use hazard SHALL exist when all of the following hold: EX_VLD_o=1, RSLT_o=1, EX_RD_o!=0, INSTR_VLD_i=1, and EX_RD_o equals a source actually read (RS1 for all except lui/auipc/jal; RS2 for op/store/branch).
REQ-009 On a hazard, ID_STALL_o SHALL be 1 and a bubble SHALL be inserted: next EX_VLD_o=0 and all controls 0.
REQ-010 FSM states SHALL be IDLE, MD_RUN and MD_DONE:
- IDLE -> MD_RUN on acceptance of an M op; the counter loads lat-1.
- MD_RUN decrements the counter; at 0 it goes to MD_DONE.
- MD_DONE -> IDLE after one cycle.
REQ-011 In MD_RUN: EX register frozen holding the M op, EX_VLD_o=0, MD_BUSY_o=1, ID_STALL_o=1.
REQ-012 In MD_DONE: EX_VLD_o=1, MD_BUSY_o=0, ID_STALL_o=1.
REQ-013 When M_EXT=0, an M op SHALL decode as illegal.
REQ-014 An illegal or unknown opcode SHALL pulse ILLEGAL_o for one cycle and insert a bubble.
REQ-015 Priority SHALL be RST_i > FLUSH_i > STALL_i > MD sequencing > load-use > normal issue.
REQ-016 FLUSH_i SHALL take effect next edge: EX_VLD_o=0, controls 0, ILLEGAL_o=0, FSM->IDLE, counter=0, including mid-MD_RUN abort.
REQ-017 STALL_i (without FLUSH_i) SHALL hold the EX register, FSM and counter unchanged, and force ID_STALL_o=1.
REQ-018 INSTR_VLD_i=0 SHALL issue a bubble.

Reset
REQ-019 While RST_i=1:
- All registered outputs SHALL be 0 (EX_VLD_o, EX_RD_o, all controls, ILLEGAL_o, MD_BUSY_o).
- FSM SHALL be IDLE and the counter 0.
REQ-020 Reset asserted mid-MD_RUN SHALL abort immediately and asynchronously.
REQ-021 Operation SHALL begin on the first rising edge after deassertion.

Structure
REQ-022 Package ctrl_pkg SHALL hold the opcode constants, the FSM state enum, the BRANCH/JUMP/RSLT/IMM_SRC encodings and the ALU_CTRL codes.
REQ-023 Combinational decoding SHALL live in sub-module ctrl_decode, instantiated once.
REQ-024 The hazard logic, FSM, counter and EX register SHALL live in ctrl_pipe_unit.

Verification
REQ-025 add x3,x1,x2 (funct7[5]=0) -> next cycle: EX_VLD_o=1, REG_WRT_o=1, ALU_CTRL_o=00000, RSLT_o=0, EX_RD_o=3.
REQ-026 lw x5 followed by add x6,x5,x1 -> ID_STALL_o=1 for one cycle, one bubble (EX_VLD_o=0), then add issues.
REQ-027 mul (MUL_LAT=4) -> MD_BUSY_o=1 for 4 cycles, then MD_DONE with EX_VLD_o=1, ALU_CTRL_o=10000; ID_STALL_o=1 for 5 cycles total.
REQ-028 div with FLUSH_i asserted in the 3rd busy cycle -> next edge: IDLE, MD_BUSY_o=0, EX_VLD_o=0.
REQ-029 beq with STALL_i=1 for 2 cycles -> BRANCH_o=1 held steady throughout, EX_VLD_o unchanged.
REQ-030 M_EXT=0, mul -> ILLEGAL_o=1 for one cycle, bubble issued; RST_i pulse mid-MD_RUN -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared opcode constants, FSM states and EX-stage control encodings for
// the decode/control pipeline.
package ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // funct7 value that selects the multiply/divide group within OPC_OP
    localparam logic [6:0] F7_MEXT    = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MD_RUN  = 2'd1,
        ST_MD_DONE = 2'd2
    } md_state_t;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;

    localparam logic [1:0] JMP_NONE = 2'd0;
    localparam logic [1:0] JMP_JAL  = 2'd1;
    localparam logic [1:0] JMP_JALR = 2'd2;

    localparam logic [1:0] RSLT_ALU   = 2'd0;
    localparam logic [1:0] RSLT_LOAD  = 2'd1;
    localparam logic [1:0] RSLT_JAL   = 2'd2;
    localparam logic [1:0] RSLT_UPPER = 2'd3;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_U = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [4:0] ALU_ADD    = 5'b00000;
    localparam logic [4:0] ALU_BRANCH = 5'b00001;

    typedef struct packed {
        logic [1:0] jump;
        logic [2:0] branch;
        logic [1:0] rslt;
        logic       mem_wrt;
        logic       alu_src;
        logic [1:0] imm_src;
        logic       reg_wrt;
        logic [4:0] alu_ctrl;
    } ex_ctrl_t;

    // Integer ALU code: funct3 plus an optional modifier bit in the LSB
    function automatic logic [4:0] alu_code(input logic [2:0] f3, input logic f7b5);
        return {1'b0, f3, f7b5};
    endfunction

    // Multiply/divide code: MSB set marks the multi-cycle unit
    function automatic logic [4:0] md_code(input logic [2:0] f3);
        return {2'b10, f3};
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational instruction decode: EX control word, multi-cycle
// classification, illegal detection and which source registers are read.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int M_EXT = 1
) (
    input  logic [6:0] i_op,
    input  logic [2:0] i_f3,
    input  logic [6:0] i_f7,
    output ex_ctrl_t   o_ctrl,
    output logic       o_md,
    output logic       o_div,
    output logic       o_illegal,
    output logic       o_use_rs1,
    output logic       o_use_rs2
);

    localparam logic M_ON = (M_EXT != 0);

    // Opcode-driven decode; unknown opcodes fall through to illegal
    always_comb begin
        o_ctrl    = '0;
        o_md      = 1'b0;
        o_div     = 1'b0;
        o_illegal = 1'b0;
        o_use_rs1 = 1'b0;
        o_use_rs2 = 1'b0;
        case (i_op)
            OPC_OP: begin
                if (i_f7 == F7_MEXT) begin
                    if (M_ON) begin
                        o_use_rs1       = 1'b1;
                        o_use_rs2       = 1'b1;
                        o_ctrl.reg_wrt  = 1'b1;
                        o_ctrl.alu_ctrl = md_code(i_f3);
                        o_md            = 1'b1;
                        o_div           = i_f3[2];
                    end else begin
                        o_illegal = 1'b1;
                    end
                end else begin
                    o_use_rs1       = 1'b1;
                    o_use_rs2       = 1'b1;
                    o_ctrl.reg_wrt  = 1'b1;
                    o_ctrl.alu_ctrl = alu_code(i_f3, i_f7[5]);
                end
            end
            OPC_OPIMM: begin
                o_use_rs1       = 1'b1;
                o_ctrl.alu_src  = 1'b1;
                o_ctrl.reg_wrt  = 1'b1;
                // only the shift-right group uses funct7[5] (logical vs arithmetic)
                o_ctrl.alu_ctrl = alu_code(i_f3, (i_f3 == 3'd5) ? i_f7[5] : 1'b0);
            end
            OPC_LOAD: begin
                o_use_rs1       = 1'b1;
                o_ctrl.alu_src  = 1'b1;
                o_ctrl.reg_wrt  = 1'b1;
                o_ctrl.rslt     = RSLT_LOAD;
                o_ctrl.alu_ctrl = ALU_ADD;
            end
            OPC_STORE: begin
                o_use_rs1       = 1'b1;
                o_use_rs2       = 1'b1;
                o_ctrl.alu_src  = 1'b1;
                o_ctrl.mem_wrt  = 1'b1;
                o_ctrl.alu_ctrl = alu_code(i_f3, 1'b0);
            end
            OPC_BRANCH: begin
                o_use_rs1       = 1'b1;
                o_use_rs2       = 1'b1;
                o_ctrl.imm_src  = IMM_B;
                o_ctrl.alu_ctrl = ALU_BRANCH;
                case (i_f3)
                    3'b000:        o_ctrl.branch = BR_BEQ;
                    3'b001:        o_ctrl.branch = BR_BNE;
                    3'b100, 3'b110: o_ctrl.branch = BR_BLT;
                    3'b101, 3'b111: o_ctrl.branch = BR_BGE;
                    default:       o_ctrl.branch = BR_NONE;
                endcase
            end
            OPC_JAL: begin
                o_ctrl.jump     = JMP_JAL;
                o_ctrl.rslt     = RSLT_JAL;
                o_ctrl.imm_src  = IMM_J;
                o_ctrl.reg_wrt  = 1'b1;
                o_ctrl.alu_ctrl = alu_code(i_f3, 1'b0);
            end
            OPC_JALR: begin
                o_use_rs1       = 1'b1;
                o_ctrl.jump     = JMP_JALR;
                o_ctrl.alu_src  = 1'b1;
                o_ctrl.reg_wrt  = 1'b1;
                o_ctrl.alu_ctrl = ALU_ADD;
            end
            OPC_LUI, OPC_AUIPC: begin
                o_ctrl.rslt     = RSLT_UPPER;
                o_ctrl.imm_src  = IMM_U;
                o_ctrl.reg_wrt  = 1'b1;
                o_ctrl.alu_ctrl = alu_code(i_f3, 1'b0);
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// ID->EX control pipeline register with load-use hazard detection and a
// small FSM that sequences multi-cycle multiply/divide operations.
module ctrl_pipe_unit
    import ctrl_pkg::*;
#(
    parameter int M_EXT   = 1,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic       CLK_i,
    input  logic       RST_i,
    input  logic       INSTR_VLD_i,
    input  logic [6:0] OP_CD_i,
    input  logic [2:0] FUNCT3_i,
    input  logic [6:0] FUNCT7_i,
    input  logic [4:0] RS1_i,
    input  logic [4:0] RS2_i,
    input  logic [4:0] RD_i,
    input  logic       STALL_i,
    input  logic       FLUSH_i,
    output logic [1:0] JUMP_o,
    output logic [2:0] BRANCH_o,
    output logic [1:0] RSLT_o,
    output logic       MEM_WRT_o,
    output logic       ALU_SRC_o,
    output logic [1:0] IMM_SRC_o,
    output logic       REG_WRT_o,
    output logic [4:0] ALU_CTRL_o,
    output logic       EX_VLD_o,
    output logic [4:0] EX_RD_o,
    output logic       ID_STALL_o,
    output logic       MD_BUSY_o,
    output logic       ILLEGAL_o
);

    // Counter preload values: the counter runs lat-1 down to 0 inclusive
    localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);

    ex_ctrl_t  w_ctrl;
    logic      w_md;
    logic      w_div;
    logic      w_illegal;
    logic      w_use_rs1;
    logic      w_use_rs2;
    logic      w_hazard;

    ex_ctrl_t  r_ex_p1;
    logic      r_vld_p1;
    logic [4:0] r_rd_p1;
    logic      r_illegal;
    md_state_t r_state;
    logic [5:0] r_cnt;

    ctrl_decode #(
        .M_EXT(M_EXT)
    ) u_decode (
        .i_op      (OP_CD_i),
        .i_f3      (FUNCT3_i),
        .i_f7      (FUNCT7_i),
        .o_ctrl    (w_ctrl),
        .o_md      (w_md),
        .o_div     (w_div),
        .o_illegal (w_illegal),
        .o_use_rs1 (w_use_rs1),
        .o_use_rs2 (w_use_rs2)
    );

    // Load-use: the load in EX cannot forward to a source read in ID
    always_comb begin
        w_hazard = r_vld_p1 && (r_ex_p1.rslt == RSLT_LOAD) && (r_rd_p1 != 5'd0) &&
                   INSTR_VLD_i &&
                   ((w_use_rs1 && (RS1_i == r_rd_p1)) ||
                    (w_use_rs2 && (RS2_i == r_rd_p1)));
    end

    assign ID_STALL_o = STALL_i || (r_state != ST_IDLE) || w_hazard;
    assign MD_BUSY_o  = (r_state == ST_MD_RUN);

    assign JUMP_o     = r_ex_p1.jump;
    assign BRANCH_o   = r_ex_p1.branch;
    assign RSLT_o     = r_ex_p1.rslt;
    assign MEM_WRT_o  = r_ex_p1.mem_wrt;
    assign ALU_SRC_o  = r_ex_p1.alu_src;
    assign IMM_SRC_o  = r_ex_p1.imm_src;
    assign REG_WRT_o  = r_ex_p1.reg_wrt;
    assign ALU_CTRL_o = r_ex_p1.alu_ctrl;
    assign EX_VLD_o   = r_vld_p1;
    assign EX_RD_o    = r_rd_p1;
    assign ILLEGAL_o  = r_illegal;

    // EX register, illegal flag, MD FSM and counter in priority order
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            r_ex_p1   <= '0;
            r_vld_p1  <= 1'b0;
            r_rd_p1   <= 5'd0;
            r_illegal <= 1'b0;
            r_state   <= ST_IDLE;
            r_cnt     <= 6'd0;
        end else if (FLUSH_i) begin
            r_ex_p1   <= '0;
            r_vld_p1  <= 1'b0;
            r_rd_p1   <= 5'd0;
            r_illegal <= 1'b0;
            r_state   <= ST_IDLE;
            r_cnt     <= 6'd0;
        end else if (STALL_i) begin
            // EX contents, FSM and counter hold; the illegal flag stays a pulse
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= 1'b0;
            case (r_state)
                ST_MD_RUN: begin
                    // EX holds the M op invisibly until the result is ready
                    if (r_cnt == 6'd0) begin
                        r_state  <= ST_MD_DONE;
                        r_vld_p1 <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 6'd1;
                    end
                end
                ST_MD_DONE: begin
                    // ID was held this cycle, so nothing new enters EX
                    r_ex_p1  <= '0;
                    r_vld_p1 <= 1'b0;
                    r_rd_p1  <= 5'd0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    if (!INSTR_VLD_i || w_hazard || w_illegal) begin
                        r_ex_p1   <= '0;
                        r_vld_p1  <= 1'b0;
                        r_rd_p1   <= 5'd0;
                        r_illegal <= INSTR_VLD_i && !w_hazard && w_illegal;
                    end else begin
                        r_ex_p1 <= w_ctrl;
                        r_rd_p1 <= RD_i;
                        if (w_md) begin
                            r_vld_p1 <= 1'b0;
                            r_state  <= ST_MD_RUN;
                            r_cnt    <= w_div ? DIV_CNT : MUL_CNT;
                        end else begin
                            r_vld_p1 <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
